c6502_serial_loader: RTL

Boot loader that sits upstream of the `c6502` core and its RAM. It receives a program image over an 8N1 serial line and writes it into RAM through a byte-wide write port. It then writes the 6502 reset vector and releases the CPU from reset. While loading, the top level muxes this block's `address`/`out`/`we` onto the RAM in place of the CPU's bus, using `busy` as the select.

---
 rtl/c6502_serial_loader.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/c6502_serial_loader.sv
// Serial boot loader for the c6502 core: receives an 8N1 framed program image,
// writes it into RAM, installs the reset vector and then releases the CPU.
module c6502_serial_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'h5A
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] address,
    output logic [7:0]  out,
    output logic        we,
    output logic        cpu_reset_n,
    output logic        busy,
    output logic        error
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [3:0] {
        S_SYNC,
        S_ALO,
        S_AHI,
        S_LLO,
        S_LHI,
        S_DATA,
        S_CSUM,
        S_VLO,
        S_VHI,
        S_RUN
    } frame_state_t;

    logic             r_rxMeta;
    logic             r_rxSync;
    logic             r_rxPrev;
    rx_state_t        r_rxState;
    rx_state_t        w_rxStateNext;
    logic [CNT_W-1:0] r_clkCnt;
    logic [CNT_W-1:0] w_clkCntNext;
    logic [2:0]       r_bitIdx;
    logic [2:0]       w_bitIdxNext;
    logic [7:0]       r_shift;
    logic [7:0]       w_shiftNext;
    logic             r_rxValid;
    logic             w_rxValidNext;
    logic             r_rxErr;
    logic             w_rxErrNext;
    logic [7:0]       w_rxData;

    frame_state_t     r_state;
    frame_state_t     w_stateNext;
    logic [15:0]      r_base;
    logic [15:0]      w_baseNext;
    logic [15:0]      r_ptr;
    logic [15:0]      w_ptrNext;
    logic [15:0]      r_len;
    logic [15:0]      w_lenNext;
    logic [7:0]       r_sum;
    logic [7:0]       w_sumNext;
    logic             r_error;
    logic             w_errorNext;
    logic             w_wrEn;
    logic [15:0]      w_wrAddr;
    logic [7:0]       w_wrData;
    logic [15:0]      r_address;
    logic [7:0]       r_out;
    logic             r_we;
    logic             r_cpuResetN;

    // The line idles high, so synchronizer flops reset to 1 to avoid a false start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rxMeta  <= 1'b1;
            r_rxSync  <= 1'b1;
            r_rxPrev  <= 1'b1;
            r_rxState <= RX_IDLE;
            r_clkCnt  <= '0;
            r_bitIdx  <= 3'd0;
            r_shift   <= 8'h00;
            r_rxValid <= 1'b0;
            r_rxErr   <= 1'b0;
        end else begin
            r_rxMeta  <= rx;
            r_rxSync  <= r_rxMeta;
            r_rxPrev  <= r_rxSync;
            r_rxState <= w_rxStateNext;
            r_clkCnt  <= w_clkCntNext;
            r_bitIdx  <= w_bitIdxNext;
            r_shift   <= w_shiftNext;
            r_rxValid <= w_rxValidNext;
            r_rxErr   <= w_rxErrNext;
        end
    end

    always_comb begin
        w_rxStateNext = r_rxState;
        w_clkCntNext  = r_clkCnt + 1'b1;
        w_bitIdxNext  = r_bitIdx;
        w_shiftNext   = r_shift;
        w_rxValidNext = 1'b0;
        w_rxErrNext   = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                w_clkCntNext = '0;
                if (r_rxPrev && !r_rxSync) begin
                    w_rxStateNext = RX_START;
                end
            end
            RX_START: begin
                if (r_clkCnt == HALF_LAST) begin
                    w_clkCntNext = '0;
                    w_bitIdxNext = 3'd0;
                    w_rxStateNext = r_rxSync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_clkCnt == BIT_LAST) begin
                    w_clkCntNext = '0;
                    w_shiftNext  = {r_rxSync, r_shift[7:1]};
                    w_bitIdxNext = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
                        w_rxStateNext = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_clkCnt == BIT_LAST) begin
                    w_clkCntNext  = '0;
                    w_rxStateNext = RX_IDLE;
                    w_rxValidNext = r_rxSync;
                    w_rxErrNext   = !r_rxSync;
                end
            end
            default: begin
                w_rxStateNext = RX_IDLE;
                w_clkCntNext  = '0;
            end
        endcase
    end

    // The shift register is untouched until the next start bit, so it doubles as the data latch.
    assign w_rxData = r_shift;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_SYNC;
            r_base      <= 16'h0000;
            r_ptr       <= 16'h0000;
            r_len       <= 16'h0000;
            r_sum       <= 8'h00;
            r_error     <= 1'b0;
            r_address   <= 16'h0000;
            r_out       <= 8'h00;
            r_we        <= 1'b0;
            r_cpuResetN <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_base      <= w_baseNext;
            r_ptr       <= w_ptrNext;
            r_len       <= w_lenNext;
            r_sum       <= w_sumNext;
            r_error     <= w_errorNext;
            r_we        <= w_wrEn;
            r_cpuResetN <= (w_stateNext == S_RUN);
            if (w_wrEn) begin
                r_address <= w_wrAddr;
                r_out     <= w_wrData;
            end
        end
    end

    // The FFFC write is issued by the checksum decision and FFFD from S_VLO, so
    // cpu_reset_n rises three cycles after the checksum byte arrives.
    always_comb begin
        w_stateNext = r_state;
        w_baseNext  = r_base;
        w_ptrNext   = r_ptr;
        w_lenNext   = r_len;
        w_sumNext   = r_sum;
        w_errorNext = r_error;
        w_wrEn      = 1'b0;
        w_wrAddr    = r_ptr;
        w_wrData    = w_rxData;
        if (r_rxErr) begin
            w_stateNext = S_SYNC;
            w_errorNext = 1'b1;
        end else begin
            case (r_state)
                S_SYNC, S_RUN: begin
                    if (r_rxValid && (w_rxData == SYNC_BYTE)) begin
                        w_stateNext = S_ALO;
                        w_sumNext   = 8'h00;
                        w_errorNext = 1'b0;
                    end
                end
                S_ALO: begin
                    if (r_rxValid) begin
                        w_baseNext[7:0] = w_rxData;
                        w_ptrNext[7:0]  = w_rxData;
                        w_stateNext     = S_AHI;
                    end
                end
                S_AHI: begin
                    if (r_rxValid) begin
                        w_baseNext[15:8] = w_rxData;
                        w_ptrNext[15:8]  = w_rxData;
                        w_stateNext      = S_LLO;
                    end
                end
                S_LLO: begin
                    if (r_rxValid) begin
                        w_lenNext[7:0] = w_rxData;
                        w_stateNext    = S_LHI;
                    end
                end
                S_LHI: begin
                    if (r_rxValid) begin
                        w_lenNext[15:8] = w_rxData;
                        w_stateNext = ({w_rxData, r_len[7:0]} == 16'h0000) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_rxValid) begin
                        w_wrEn    = 1'b1;
                        w_ptrNext = r_ptr + 16'h0001;
                        w_sumNext = r_sum + w_rxData;
                        w_lenNext = r_len - 16'h0001;
                        if (r_len == 16'h0001) begin
                            w_stateNext = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (r_rxValid) begin
                        if (w_rxData == r_sum) begin
                            w_wrEn      = 1'b1;
                            w_wrAddr    = 16'hFFFC;
                            w_wrData    = r_base[7:0];
                            w_stateNext = S_VLO;
                        end else begin
                            w_errorNext = 1'b1;
                            w_stateNext = S_SYNC;
                        end
                    end
                end
                S_VLO: begin
                    w_wrEn      = 1'b1;
                    w_wrAddr    = 16'hFFFD;
                    w_wrData    = r_base[15:8];
                    w_stateNext = S_VHI;
                end
                S_VHI: begin
                    w_stateNext = S_RUN;
                end
                default: begin
                    w_stateNext = S_SYNC;
                end
            endcase
        end
    end

    assign address     = r_address;
    assign out         = r_out;
    assign we          = r_we;
    assign cpu_reset_n = r_cpuResetN;
    assign busy        = ~r_cpuResetN;
    assign error       = r_error;

endmodule
